// File: rtl/ir_queue.sv
// Instruction register plus prefetch queue: packs NBYTES bus bytes (MS byte first) into one
// instruction word and buffers up to DEPTH words for the decoder under valid/ready.
module ir_queue #(
  parameter int DATA_W = 8,
  parameter int NBYTES = 2,
  parameter int DEPTH  = 4,
  localparam int IW = DATA_W * NBYTES,
  localparam int PW = IW - DATA_W,
  localparam int SW = $clog2(NBYTES),
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_clk,
  input  logic              flush,
  input  logic [DATA_W-1:0] data,
  input  logic              data_valid,
  output logic              data_ready,
  output logic [IW-1:0]     op_ir,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [SW-1:0]     state,
  output logic [CW-1:0]     count
);

  logic [SW-1:0] state_q, state_d;
  logic [PW-1:0] partial_q, partial_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [IW-1:0] mem_q [DEPTH];

  logic lastSlot;
  logic transfer;
  logic push;
  logic pop;

  assign lastSlot   = (state_q == SW'(NBYTES - 1));
  assign data_ready = !(lastSlot && (count_q == CW'(DEPTH)));
  assign op_valid   = (count_q != '0);
  assign op_ir      = op_valid ? mem_q[rdPtr_q] : '0;
  assign state      = state_q;
  assign count      = count_q;

  assign transfer = data_valid && data_ready && !flush;
  assign push     = transfer && lastSlot;
  assign pop      = op_valid && op_ready && !flush;

  always_comb begin
    state_d   = state_q;
    partial_d = partial_q;
    count_d   = count_q;
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    if (flush) begin
      state_d   = '0;
      partial_d = '0;
      count_d   = '0;
      wrPtr_d   = '0;
      rdPtr_d   = '0;
    end else begin
      if (transfer) begin
        if (lastSlot) begin
          state_d   = '0;
          partial_d = '0;
        end else begin
          // Slot 0 is the most significant byte of the assembled word.
          partial_d[PW - 1 - int'(state_q) * DATA_W -: DATA_W] = data;
          state_d = state_q + SW'(1);
        end
      end
      if (push) wrPtr_d = wrPtr_q + AW'(1);
      if (pop)  rdPtr_d = rdPtr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_clk) begin
      state_q   <= '0;
      partial_q <= '0;
      count_q   <= '0;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      partial_q <= partial_d;
      count_q   <= count_d;
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      if (push) mem_q[wrPtr_q] <= {partial_q, data};
    end
  end

endmodule
